sh_mem_bank_arbiter: RTL and testbench

Per-bank access controller for the shared memory. It takes packed read/write requests from all cores and picks one requester per cycle with a round-robin policy. It muxes the winner's address and write data onto a single bank port, and tracks outstanding reads through a fixed-latency tag pipeline so each read datum goes back to the core that issued it. One instance sits in front of each bank.

---
 rtl/sh_mem_bank_arbiter_pkg.sv | 29 ++
 rtl/sh_mem_bank_arbiter_rr_pick.sv | 34 +++
 rtl/sh_mem_bank_arbiter.sv | 127 ++++++++++++
 tb/tb_sh_mem_bank_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sh_mem_bank_arbiter_pkg.sv
// Shared definitions for the per-bank shared-memory arbiter.
// Request codes, the core-id width helper and the read tag record.
// No logic. Everything here is constants and types.
package sh_mem_bank_arbiter_pkg;

  localparam logic [1:0] REQ_IDLE = 2'b00;
  localparam logic [1:0] REQ_RD   = 2'b01;
  localparam logic [1:0] REQ_WR   = 2'b10;
  localparam logic [1:0] REQ_ILL  = 2'b11;

  // Tags carry a fixed-width id, so NUM_CORES must not exceed 2**TAG_ID_W.
  localparam int TAG_ID_W = 8;

  // Returns the bits needed to hold a core id. Never returns less than 1.
  function automatic int id_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/sh_mem_bank_arbiter_rr_pick.sv
// Round-robin pick: the first set bit of elig, starting at start and wrapping at N.
// Latency: combinational, 0 cycles.
// Backpressure: none. The caller masks ineligible requesters through elig.
module sh_mem_bank_arbiter_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    elig,
  input  logic [ID_W-1:0] start,
  output logic            found,
  output logic [ID_W-1:0] winner
);

  int              idx;
  logic [ID_W-1:0] idx_l;

  // Walk the N candidates from start. Wrap explicitly so N need not be a power of two.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_l  = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      idx_l = idx[ID_W-1:0];
      if (!found && elig[idx_l]) begin
        found  = 1'b1;
        winner = idx_l;
      end
    end
  end

endmodule

// File: rtl/sh_mem_bank_arbiter.sv
// Per-bank arbiter: a round-robin grant of one core per cycle onto a single bank port.
// Latency: the write ack and the bank strobes are in the grant cycle. Read data returns RD_LAT cycles later.
// Backpressure: a core that is not granted holds its req. A read in flight masks its core until it returns.
module sh_mem_bank_arbiter
  import sh_mem_bank_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2*NUM_CORES-1:0]      req,
  input  logic [ADDR_W*NUM_CORES-1:0] addr_in,
  input  logic [DATA_W*NUM_CORES-1:0] wr_data_in,
  output logic [NUM_CORES-1:0]        ready,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        err,
  output logic [ADDR_W-1:0]           bank_addr,
  output logic [DATA_W-1:0]           bank_wr_data,
  output logic                        bank_rd_en,
  output logic                        bank_wr_en,
  input  logic [DATA_W-1:0]           bank_rd_data
);

  localparam int ID_W = id_width(NUM_CORES);

  logic [ID_W-1:0]      last_grant;
  logic [ID_W-1:0]      start_idx;
  logic [ID_W-1:0]      win_id;
  logic                 found;
  logic [NUM_CORES-1:0] pending;
  logic [NUM_CORES-1:0] pending_nxt;
  logic [NUM_CORES-1:0] elig;
  logic                 any_ill;
  logic [1:0]           code;
  logic [1:0]           win_code;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_wdat;
  logic                 grant_rd;
  logic                 grant_wr;
  logic                 ret_vld;
  tag_t                 tag_q [RD_LAT];

  // A core is eligible when it has a legal request and no read outstanding. Code 11 is flagged.
  always_comb begin
    elig    = '0;
    any_ill = 1'b0;
    code    = REQ_IDLE;
    for (int i = 0; i < NUM_CORES; i++) begin
      code    = req[2*i +: 2];
      elig[i] = ((code == REQ_RD) || (code == REQ_WR)) && !pending[i] && !reset;
      if (code == REQ_ILL) any_ill = 1'b1;
    end
  end

  assign start_idx = (last_grant == ID_W'(NUM_CORES - 1)) ? '0 : last_grant + 1'b1;

  sh_mem_bank_arbiter_rr_pick #(
    .N    (NUM_CORES),
    .ID_W (ID_W)
  ) u_rr_pick (
    .elig   (elig),
    .start  (start_idx),
    .found  (found),
    .winner (win_id)
  );

  // Select the winner's request code, address and write data.
  always_comb begin
    win_code = REQ_IDLE;
    win_addr = '0;
    win_wdat = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (found && (win_id == ID_W'(i))) begin
        win_code = req[2*i +: 2];
        win_addr = addr_in[ADDR_W*i +: ADDR_W];
        win_wdat = wr_data_in[DATA_W*i +: DATA_W];
      end
    end
  end

  assign grant_rd     = found && (win_code == REQ_RD);
  assign grant_wr     = found && (win_code == REQ_WR);
  assign bank_rd_en   = grant_rd;
  assign bank_wr_en   = grant_wr;
  assign bank_addr    = win_addr;
  assign bank_wr_data = win_wdat;

  // During reset the returning tag is ignored, so reads in flight are dropped.
  assign ret_vld = tag_q[RD_LAT-1].valid && !reset;
  assign rd_data = ret_vld ? bank_rd_data : '0;

  // Completion strobes: the write ack to the winner and the read return to the tagged core.
  // The two strobes can fire in the same cycle, but only for different cores.
  always_comb begin
    ready       = '0;
    pending_nxt = pending;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_wr && (win_id == ID_W'(i))) ready[i] = 1'b1;
      if (ret_vld && (tag_q[RD_LAT-1].id == TAG_ID_W'(i))) begin
        ready[i]       = 1'b1;
        pending_nxt[i] = 1'b0;
      end
      if (grant_rd && (win_id == ID_W'(i))) pending_nxt[i] = 1'b1;
    end
  end

  // Arbitration pointer, outstanding-read mask, read tag pipeline and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= ID_W'(NUM_CORES - 1);
      pending    <= '0;
      err        <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      if (found) last_grant <= win_id;
      if (any_ill) err <= 1'b1;
      pending        <= pending_nxt;
      tag_q[0].valid <= grant_rd;
      tag_q[0].id    <= TAG_ID_W'(win_id);
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

endmodule

// File: tb/tb_sh_mem_bank_arbiter.sv
// Self-checking bench for sh_mem_bank_arbiter (4 cores, RD_LAT=2).
// The bench acts as the bank: a memory plus a read-latency pipe driven by the DUT's bank port.
// A queue-based reference model predicts every output, every cycle.
module tb_sh_mem_bank_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [2*N-1:0]  req;
  logic [AW*N-1:0] addr_in;
  logic [DW*N-1:0] wr_data_in;
  logic [N-1:0]    ready;
  logic [DW-1:0]   rd_data;
  logic            err;
  logic [AW-1:0]   bank_addr;
  logic [DW-1:0]   bank_wr_data;
  logic            bank_rd_en;
  logic            bank_wr_en;
  logic [DW-1:0]   bank_rd_data;

  always #5 clk = ~clk;

  sh_mem_bank_arbiter #(
    .NUM_CORES (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RD_LAT    (RL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .addr_in      (addr_in),
    .wr_data_in   (wr_data_in),
    .ready        (ready),
    .rd_data      (rd_data),
    .err          (err),
    .bank_addr    (bank_addr),
    .bank_wr_data (bank_wr_data),
    .bank_rd_en   (bank_rd_en),
    .bank_wr_en   (bank_wr_en),
    .bank_rd_data (bank_rd_data)
  );

  // Bank environment. Idle cycles return junk so that unmasked rd_data is caught.
  bit   [DW-1:0] mem [256];
  logic [DW-1:0] rp  [RL];
  always @(posedge clk) begin
    if (bank_wr_en) mem[bank_addr] <= bank_wr_data;
    rp[0] <= bank_rd_en ? mem[bank_addr] : DW'($urandom);
    for (int i = 1; i < RL; i++) rp[i] <= rp[i-1];
  end
  assign bank_rd_data = rp[RL-1];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Per-core stimulus: code, address and write data.
  logic [1:0]    rq [N];
  logic [AW-1:0] ad [N];
  logic [DW-1:0] wd [N];

  // Reference model: the last winner, the sticky error, a memory image and the reads in flight.
  typedef struct {
    int          core;
    int          due;
    bit [DW-1:0] data;
  } fl_t;
  int            last_g;
  bit            m_err;
  bit   [DW-1:0] m_mem [256];
  fl_t           fl [$];
  int            cyc = 0;
  logic [N-1:0]  exp_ready;

  function automatic bit busy(input int c);
    foreach (fl[k]) if (fl[k].core == c) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive the inputs, predict, compare, then advance the model past the edge.
  task automatic cycle(input logic rst_v);
    int            win;
    int            ret_k;
    int            c;
    logic [DW-1:0] e_rd;
    logic [DW-1:0] e_wd;
    logic [AW-1:0] e_ba;
    logic          e_re;
    logic          e_we;
    bit            ill;
    @(negedge clk);
    reset = rst_v;
    for (int i = 0; i < N; i++) begin
      req[2*i +: 2]         = rq[i];
      addr_in[AW*i +: AW]    = ad[i];
      wr_data_in[DW*i +: DW] = wd[i];
    end
    #1;
    win = -1; ret_k = -1; exp_ready = '0;
    e_rd = '0; e_wd = '0; e_ba = '0; e_re = 1'b0; e_we = 1'b0; ill = 1'b0;
    for (int i = 0; i < N; i++) if (rq[i] == 2'b11) ill = 1'b1;
    if (!rst_v) begin
      foreach (fl[k]) begin
        if (fl[k].due == cyc) begin
          ret_k = k;
          exp_ready[fl[k].core] = 1'b1;
          e_rd = fl[k].data;
        end
      end
      for (int k = 1; k <= N; k++) begin
        c = (last_g + k) % N;
        if (win < 0 && (rq[c] == 2'b01 || rq[c] == 2'b10) && !busy(c)) win = c;
      end
      if (win >= 0) begin
        e_ba = ad[win];
        e_wd = wd[win];
        e_re = (rq[win] == 2'b01);
        e_we = (rq[win] == 2'b10);
        if (e_we) exp_ready[win] = 1'b1;
      end
    end
    chk("ready",        ready,        exp_ready);
    chk("rd_data",      rd_data,      e_rd);
    chk("bank_rd_en",   bank_rd_en,   e_re);
    chk("bank_wr_en",   bank_wr_en,   e_we);
    chk("bank_addr",    bank_addr,    e_ba);
    chk("bank_wr_data", bank_wr_data, e_wd);
    if (!rst_v) chk("err", err, m_err);
    if (rst_v) begin
      fl.delete();
      last_g = N - 1;
      m_err  = 1'b0;
    end else begin
      if (ret_k >= 0) fl.delete(ret_k);
      if (win >= 0) begin
        if (e_re) fl.push_back('{core: win, due: cyc + RL, data: m_mem[ad[win]]});
        else m_mem[ad[win]] = wd[win];
        last_g = win;
      end
      if (ill) m_err = 1'b1;
    end
    cyc++;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      rq[i] = 2'b00; ad[i] = '0; wd[i] = '0;
    end
  endtask

  int r;

  initial begin
    idle_all();
    reset = 1'b1;
    req = '0; addr_in = '0; wr_data_in = '0;

    // Reset, then check the reset state with every core idle.
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b0);
    chk("rst_err",   err,   1'b0);
    chk("rst_ready", ready, 4'b0000);

    // Core 0 writes, then core 2 reads the same word back.
    rq[0] = 2'b10; ad[0] = 8'h05; wd[0] = 16'hABCD;
    cycle(1'b0);
    chk("wr_en",    bank_wr_en,   1'b1);
    chk("wr_addr",  bank_addr,    8'h05);
    chk("wr_data",  bank_wr_data, 16'hABCD);
    chk("wr_ready", ready,        4'b0001);
    rq[0] = 2'b00;
    rq[2] = 2'b01; ad[2] = 8'h05;
    cycle(1'b0);
    chk("rd_grant",   bank_rd_en, 1'b1);
    chk("rd_noready", ready,      4'b0000);
    cycle(1'b0);
    chk("rd_wait", ready, 4'b0000);
    cycle(1'b0);
    chk("rd_ready", ready,   4'b0100);
    chk("rd_val",   rd_data, 16'hABCD);
    rq[2] = 2'b00;

    // Fairness: all four cores write continuously, so grants rotate 0,1,2,3,0.
    cycle(1'b1);
    for (int i = 0; i < N; i++) begin
      rq[i] = 2'b10; ad[i] = AW'(8'h10 + i); wd[i] = DW'(i + 1);
    end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0);
      chk($sformatf("rr_ready%0d", k), ready, 32'(1 << (k % N)));
    end
    idle_all();

    // In-flight masking: core 1 reads while core 3 writes.
    cycle(1'b1);
    rq[1] = 2'b01; ad[1] = 8'h05;
    rq[3] = 2'b10; ad[3] = 8'h30; wd[3] = 16'h3333;
    cycle(1'b0);
    chk("mask_c0_rd", bank_rd_en, 1'b1);
    cycle(1'b0);
    chk("mask_c1_ready", ready, 4'b1000);
    rq[3] = 2'b00;
    cycle(1'b0);
    chk("mask_c2_ready", ready,      4'b0010);
    chk("mask_c2_data",  rd_data,    16'hABCD);
    chk("mask_c2_norg",  bank_rd_en, 1'b0);
    cycle(1'b0);
    chk("mask_c3_regrant", bank_rd_en, 1'b1);
    rq[1] = 2'b00;
    cycle(1'b0);
    cycle(1'b0);

    // Illegal code: never granted, err is sticky until reset.
    rq[2] = 2'b11;
    cycle(1'b0);
    chk("ill_c0_strobe", bank_wr_en | bank_rd_en, 1'b0);
    cycle(1'b0);
    chk("ill_c1_err", err, 1'b1);
    rq[2] = 2'b00;
    cycle(1'b0);
    chk("ill_sticky", err, 1'b1);
    cycle(1'b1);
    cycle(1'b0);
    chk("ill_cleared", err, 1'b0);

    // Reset while a read is in flight: its data is never returned.
    rq[0] = 2'b01; ad[0] = 8'h05;
    cycle(1'b0);
    chk("rstrd_grant", bank_rd_en, 1'b1);
    cycle(1'b1);
    chk("rstrd_c1", ready, 4'b0000);
    rq[0] = 2'b00;
    cycle(1'b0);
    chk("rstrd_drop", ready, 4'b0000);
    rq[0] = 2'b10; ad[0] = 8'h20; wd[0] = 16'h2020;
    rq[1] = 2'b10; ad[1] = 8'h21; wd[1] = 16'h2121;
    cycle(1'b0);
    chk("rstrd_core0_first", ready, 4'b0001);
    rq[0] = 2'b00;
    cycle(1'b0);
    chk("rstrd_core1_next", ready, 4'b0010);
    idle_all();

    // Overlap: core 0's read returns in the same cycle that core 1's write is acked.
    rq[0] = 2'b01; ad[0] = 8'h05;
    cycle(1'b0);
    chk("ovl_rd", bank_rd_en, 1'b1);
    cycle(1'b0);
    rq[1] = 2'b10; ad[1] = 8'h40; wd[1] = 16'h4444;
    cycle(1'b0);
    chk("ovl_ready", ready,      4'b0011);
    chk("ovl_data",  rd_data,    16'hABCD);
    chk("ovl_wr",    bank_wr_en, 1'b1);
    idle_all();
    cycle(1'b0);

    // Random traffic with occasional resets. Cores hold requests until their ready.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (rq[i] == 2'b00 || exp_ready[i]) begin
          r = $urandom_range(0, 9);
          rq[i] = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : 2'b10;
          ad[i] = AW'($urandom_range(0, 15));
          wd[i] = DW'($urandom);
        end
      end
      cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
